reg_file: RTL and testbench

General-purpose register file for the SRP16 core, directly downstream of `control_decode`. It consumes the decoder's `reg_file_*` control lines and shared data bus, and holds 32 16-bit registers R0–R31. It updates state on the rising clock edge, half a cycle after the decoder launches controls on the falling edge. It provides byte-lane (upper) access, in-place increment/decrement, a debug read port and a sticky protocol-error flag.

---
 rtl/reg_file_if.sv | 42 ++++
 rtl/reg_file.sv | 102 ++++++++++
 tb/tb_reg_file.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Decoder-side control/data bus of the SRP16 register file.
//               The shared data bus is resolved here so the tristate stays in
//               one scope; the register file supplies value and drive enable.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if;
  logic        reg_file_read;
  logic        reg_file_readu;
  logic        reg_file_write;
  logic        reg_file_writu;
  logic        reg_file_inc;
  logic        reg_file_dec;
  logic [5:0]  reg_file_id;
  logic [15:0] din;
  logic [4:0]  dbg_id;
  logic        err_clear;

  logic [15:0] dout_val;
  logic        dout_oe;
  logic [15:0] dbg_data;
  logic        err;

  // Shared data bus: released to high-Z whenever the register file is not reading.
  wire  [15:0] dout;
  assign dout = dout_oe ? dout_val : 16'hzzzz;

  modport master (
    output reg_file_read, reg_file_readu, reg_file_write, reg_file_writu,
    output reg_file_inc, reg_file_dec, reg_file_id, din, dbg_id, err_clear,
    input  dout, dout_oe, dbg_data, err
  );

  modport slave (
    input  reg_file_read, reg_file_readu, reg_file_write, reg_file_writu,
    input  reg_file_inc, reg_file_dec, reg_file_id, din, dbg_id, err_clear,
    output dout_val, dout_oe, dbg_data, err
  );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : SRP16 general-purpose register file. Combinational word and
//               upper-byte reads, one write-type action per rising edge
//               (write > writu > inc > dec), debug read port and a sticky
//               protocol-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int NREGS = 32,
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  localparam logic [6:0] c_nregs = 7'(NREGS);

  logic             w_sel_ok;
  logic             w_any_rd;
  logic             w_any_wr;
  logic [2:0]       w_nwr;
  logic             w_multi_wr;
  logic             w_err_cond;
  logic             w_we;
  logic [4:0]       w_idx;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_regs [32];
  logic             r_err;

  // Ids 32..63 belong to special registers elsewhere, so the compare is done
  // on the full 6-bit id before the 5-bit index is used.
  assign w_sel_ok   = ({1'b0, bus.reg_file_id} < c_nregs);
  assign w_idx      = bus.reg_file_id[4:0];
  assign w_any_rd   = bus.reg_file_read | bus.reg_file_readu;
  assign w_any_wr   = bus.reg_file_write | bus.reg_file_writu |
                      bus.reg_file_inc   | bus.reg_file_dec;
  assign w_nwr      = 3'(bus.reg_file_write) + 3'(bus.reg_file_writu) +
                      3'(bus.reg_file_inc)   + 3'(bus.reg_file_dec);
  assign w_multi_wr = (w_nwr > 3'd1);
  assign w_err_cond = w_multi_wr
                    | (w_any_rd & w_any_wr)
                    | (bus.reg_file_read & bus.reg_file_readu)
                    | (~w_sel_ok & (w_any_rd | w_any_wr));

  // A read in the same cycle suppresses the write so the bus sees the old value.
  assign w_we  = w_sel_ok & w_any_wr & ~w_any_rd;
  assign w_cur = w_regs[w_idx];

  // Single write-type action in priority order; inc and dec together cancel.
  always_comb begin
    w_next = w_cur;
    if (bus.reg_file_write)
      w_next = bus.din;
    else if (bus.reg_file_writu)
      w_next = {bus.din[7:0], w_cur[7:0]};
    else if (bus.reg_file_inc && !bus.reg_file_dec)
      w_next = w_cur + 1'b1;
    else if (bus.reg_file_dec && !bus.reg_file_inc)
      w_next = w_cur - 1'b1;
  end

  generate
    for (genvar i = 0; i < 32; i++) begin : g_reg
      if (i < NREGS) begin : g_live
        logic [WIDTH-1:0] r_q;
        // Register i: cleared asynchronously, loaded when selected.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset)
            r_q <= '0;
          else if (w_we && (w_idx == 5'(i)))
            r_q <= w_next;
        end
        assign w_regs[i] = r_q;
      end else begin : g_unused
        assign w_regs[i] = '0;
      end
    end
  endgenerate

  // Sticky error: a new condition outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else if (w_err_cond)
      r_err <= 1'b1;
    else if (bus.err_clear)
      r_err <= 1'b0;
  end

  // Reads are gated by reset so the bus floats while the core is held.
  assign bus.dout_oe  = reset & w_sel_ok & w_any_rd;
  assign bus.dout_val = bus.reg_file_read ? w_cur
                                          : {{(WIDTH-8){1'b0}}, w_cur[WIDTH-1:8]};
  assign bus.dbg_data = w_regs[bus.dbg_id];
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Scoreboard bench for reg_file. Stimulus drives one decoder
//               cycle just after each falling edge and queues the values it
//               expects; the monitor checks them at the next falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  localparam int K_DOUT = 0;
  localparam int K_OE   = 1;
  localparam int K_DBG  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb [$];
  event check_now;

  reg_file_if bus ();

  reg_file #(.NREGS(32), .WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1, "timeout");
  end

  task automatic expect_val(input int kind, input logic [15:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // One decoder cycle: controls change half a cycle before the rising edge.
  task automatic drive(input logic rd, input logic rdu, input logic wr, input logic wu,
                       input logic inc, input logic dec, input logic [5:0] id,
                       input logic [15:0] d, input logic clr, input logic [4:0] dbg);
    @(negedge clk);
    #1;
    bus.reg_file_read  = rd;
    bus.reg_file_readu = rdu;
    bus.reg_file_write = wr;
    bus.reg_file_writu = wu;
    bus.reg_file_inc   = inc;
    bus.reg_file_dec   = dec;
    bus.reg_file_id    = id;
    bus.din            = d;
    bus.err_clear      = clr;
    bus.dbg_id         = dbg;
  endtask

  task automatic idle(input logic [4:0] dbg);
    drive(0, 0, 0, 0, 0, 0, 6'd0, 16'h0000, 0, dbg);
  endtask

  // Monitor: compares everything queued during the previous cycle.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk or check_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_DOUT:  act = bus.dout;
          K_OE:    act = {15'd0, bus.dout_oe};
          K_DBG:   act = bus.dbg_data;
          default: act = {15'd0, bus.err};
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.reg_file_read  = 0;
    bus.reg_file_readu = 0;
    bus.reg_file_write = 0;
    bus.reg_file_writu = 0;
    bus.reg_file_inc   = 0;
    bus.reg_file_dec   = 0;
    bus.reg_file_id    = 6'd0;
    bus.din            = 16'h0000;
    bus.err_clear      = 0;
    bus.dbg_id         = 5'd0;

    // Held in reset: writes blocked, reads floating, flag clear.
    drive(0, 0, 1, 0, 0, 0, 6'd2, 16'h1234, 0, 5'd2);
    expect_val(K_DBG, 16'h0000, "reset_write_blocked");
    expect_val(K_ERR, 16'h0000, "reset_err");
    drive(1, 0, 0, 0, 0, 0, 6'd2, 16'h0000, 0, 5'd2);
    expect_val(K_OE, 16'h0000, "reset_read_float");

    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      idle(5'(i));
      expect_val(K_DBG, 16'h0000, $sformatf("post_reset_r%0d", i));
    end
    expect_val(K_ERR, 16'h0000, "post_reset_err");
    expect_val(K_OE, 16'h0000, "post_reset_float");

    // Word write, word read, upper-byte read, upper-byte write.
    drive(0, 0, 1, 0, 0, 0, 6'd5, 16'h12F4, 0, 5'd5);
    expect_val(K_DBG, 16'h12F4, "write_r5");
    expect_val(K_ERR, 16'h0000, "write_r5_err");
    drive(1, 0, 0, 0, 0, 0, 6'd5, 16'h0000, 0, 5'd5);
    expect_val(K_OE, 16'h0001, "read_r5_oe");
    expect_val(K_DOUT, 16'h12F4, "read_r5");
    drive(0, 1, 0, 0, 0, 0, 6'd5, 16'h0000, 0, 5'd5);
    expect_val(K_DOUT, 16'h0012, "readu_r5");
    drive(0, 0, 0, 1, 0, 0, 6'd5, 16'h00AB, 0, 5'd5);
    expect_val(K_DBG, 16'hABF4, "writu_r5");

    // Increment/decrement wrap on R7.
    drive(0, 0, 1, 0, 0, 0, 6'd7, 16'hFFFF, 0, 5'd7);
    expect_val(K_DBG, 16'hFFFF, "r7_ffff");
    drive(0, 0, 0, 0, 1, 0, 6'd7, 16'h0000, 0, 5'd7);
    expect_val(K_DBG, 16'h0000, "inc_wrap");
    drive(0, 0, 0, 0, 0, 1, 6'd7, 16'h0000, 0, 5'd7);
    expect_val(K_DBG, 16'hFFFF, "dec_back");
    drive(0, 0, 1, 0, 0, 0, 6'd7, 16'h0000, 0, 5'd7);
    expect_val(K_DBG, 16'h0000, "r7_zero");
    drive(0, 0, 0, 0, 0, 1, 6'd7, 16'h0000, 0, 5'd7);
    expect_val(K_DBG, 16'hFFFF, "dec_wrap");
    expect_val(K_ERR, 16'h0000, "dec_wrap_err");
    drive(0, 0, 0, 0, 1, 1, 6'd7, 16'h0000, 0, 5'd7);
    expect_val(K_DBG, 16'hFFFF, "incdec_hold");
    expect_val(K_ERR, 16'h0001, "incdec_err");

    // Clear alone.
    drive(0, 0, 0, 0, 0, 0, 6'd0, 16'h0000, 1, 5'd7);
    expect_val(K_ERR, 16'h0000, "clear_alone");

    // Illegal id: nothing written, bus floats, error raised.
    drive(0, 0, 1, 0, 0, 0, 6'd60, 16'h5555, 0, 5'd28);
    expect_val(K_ERR, 16'h0001, "bad_id_err");
    expect_val(K_DBG, 16'h0000, "bad_id_r28");
    drive(1, 0, 0, 0, 0, 0, 6'd60, 16'h0000, 0, 5'd0);
    expect_val(K_OE, 16'h0000, "bad_id_read_float");
    for (int i = 0; i < 32; i++) begin
      idle(5'(i));
      expect_val(K_DBG, (i == 5) ? 16'hABF4 : (i == 7) ? 16'hFFFF : 16'h0000,
                 $sformatf("sweep_r%0d", i));
    end

    // Clear loses to a new condition; write wins over writu.
    drive(0, 0, 1, 1, 0, 0, 6'd1, 16'h4321, 1, 5'd1);
    expect_val(K_ERR, 16'h0001, "clear_vs_set");
    expect_val(K_DBG, 16'h4321, "write_beats_writu");
    drive(0, 0, 0, 0, 0, 0, 6'd0, 16'h0000, 1, 5'd1);
    expect_val(K_ERR, 16'h0000, "clear_again");

    // Read and write same register: old value on bus, write suppressed.
    drive(1, 0, 1, 0, 0, 0, 6'd5, 16'h0000, 0, 5'd5);
    expect_val(K_DOUT, 16'hABF4, "rw_old_value");
    expect_val(K_DBG, 16'hABF4, "rw_write_suppressed");
    expect_val(K_ERR, 16'h0001, "rw_err");

    // Asynchronous reset between edges.
    drive(0, 0, 1, 0, 0, 0, 6'd3, 16'h00C3, 0, 5'd3);
    expect_val(K_DBG, 16'h00C3, "r3_c3");
    @(negedge clk);
    #1;
    bus.reg_file_write = 0;
    reset = 1'b0;
    #1;
    expect_val(K_DBG, 16'h0000, "async_r3_cleared");
    expect_val(K_ERR, 16'h0000, "async_err_cleared");
    ->check_now;
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 6'd3, 16'h0077, 0, 5'd3);
    expect_val(K_DBG, 16'h7700, "writu_after_reset");
    drive(0, 0, 0, 0, 0, 0, 6'd0, 16'h0000, 0, 5'd5);
    expect_val(K_DBG, 16'h0000, "r5_after_reset");

    idle(5'd0);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
